// File: rtl/multicycle_control.sv
// multicycle_control: MIPS multi-cycle control FSM; MULTICYCLE_ADDI_EN makes addi legal.
module multicycle_control #(
  parameter int          CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_retired
);
  localparam logic [5:0] OP_ADDI = 6'b001000;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    EXECUTE, ALU_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB
  } state_t;
  state_t state, next, eff;
  logic legal, addi, retire;
`ifdef MULTICYCLE_ADDI_EN
  assign addi = opcode == OP_ADDI;
`else
  assign addi = 1'b0;
`endif
  assign legal = opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE ||
                 opcode == OP_BEQ || opcode == OP_J || addi;
  always_comb begin
    next = state;
    case (state)
      FETCH:     next = mem_ready ? DECODE : FETCH;
      DECODE:    next = (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                        opcode == OP_RTYPE ? EXECUTE :
                        opcode == OP_BEQ ? BRANCH :
                        opcode == OP_J ? JUMP :
                        addi ? ADDI_EX : FETCH;
      MEM_ADDR:  next = opcode == OP_LW ? MEM_READ : MEM_WRITE;
      MEM_READ:  next = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: next = mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   next = ALU_WB;
      ADDI_EX:   next = ADDI_WB;
      default:   next = FETCH;
    endcase
  end
  // Illegal opcodes leave DECODE straight for FETCH without retiring.
  assign retire = next == FETCH && state != FETCH && state != DECODE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FETCH;
      instr_retired <= '0;
    end else begin
      state <= next;
      if (retire) instr_retired <= instr_retired + 1'b1;
    end
  end
  // While reset is low the outputs show FETCH values so an aborted access never writes.
  assign eff = rst_n ? state : FETCH;
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (eff)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      DECODE:    alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB:   reg_write = 1'b1;
      default: ;
    endcase
  end
  assign illegal_op = rst_n && state == DECODE && !legal;
  assign state_dbg  = state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard of per-cycle expected control words for multicycle_control.
module tb_multicycle_control;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
  logic [31:0] instr_retired;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg),
    .instr_retired(instr_retired)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic        rst;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic [31:0] cnt;
  } rec_t;
  rec_t q[$];
  int checks = 0, fails = 0;
  logic [31:0] n = 0;
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [15:0] ctl(int s, logic r);
    case (s)
      0:  return {r, 1'b0, 1'b0, 1'b1, 1'b0, r, 4'b0000, 2'b01, 2'b00, 2'b00};
      1:  return {10'b0, 2'b11, 2'b00, 2'b00};
      2:  return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      3:  return {2'b00, 1'b1, 1'b1, 12'b0};
      4:  return {6'b0, 1'b1, 1'b0, 1'b1, 7'b0};
      5:  return {2'b00, 1'b1, 1'b0, 1'b1, 11'b0};
      6:  return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      7:  return {7'b0, 1'b1, 1'b1, 7'b0};
      8:  return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      9:  return {1'b1, 13'b0, 2'b10};
      10: return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      11: return {8'b0, 1'b1, 7'b0};
      default: return 16'hxxxx;
    endcase
  endfunction
  task automatic push(input logic [5:0] op, input int st, input logic rdy, input logic ill = 1'b0, input logic rst = 1'b1);
    rec_t r;
    r.op = op; r.rdy = rdy; r.rst = rst; r.st = 4'(st); r.ill = ill; r.cnt = n;
    r.ctl = rst ? ctl(st, rdy) : ctl(0, 1'b0);
    q.push_back(r);
    if (!rst) n = 0;
    else if (st == 4 || st == 7 || st == 8 || st == 9 || st == 11 || (st == 5 && rdy)) n = n + 1;
  endtask
  task automatic drain();
    rec_t r;
    logic [15:0] got;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      opcode = r.op; mem_ready = r.rdy; rst_n = r.rst;
      #1;
      got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
      checks++;
      assert (state_dbg === r.st) else begin fails++; $error("FAIL state t=%0t got %0d want %0d", $time, state_dbg, r.st); end
      checks++;
      assert (got === r.ctl) else begin fails++; $error("FAIL ctl st=%0d t=%0t got %h want %h", r.st, $time, got, r.ctl); end
      checks++;
      assert (illegal_op === r.ill) else begin fails++; $error("FAIL illegal t=%0t got %b want %b", $time, illegal_op, r.ill); end
      checks++;
      assert (instr_retired === r.cnt) else begin fails++; $error("FAIL retired t=%0t got %0d want %0d", $time, instr_retired, r.cnt); end
    end
  endtask
  initial begin
    @(posedge clk);
    push(0, 0, 1, 0, 0); push(0, 0, 1, 0, 0);
    // R-type, with mem_ready low in DECODE to show it is ignored there
    push(0, 0, 1); push(0, 1, 0); push(0, 6, 0); push(0, 7, 1);
    // lw with a FETCH stall and three MEM_READ wait states
    push(6'b100011, 0, 0); push(6'b100011, 0, 1); push(6'b100011, 1, 1); push(6'b100011, 2, 1);
    push(6'b100011, 3, 0); push(6'b100011, 3, 0); push(6'b100011, 3, 0); push(6'b100011, 3, 1);
    push(6'b100011, 4, 1);
    // sw, beq, j
    push(6'b101011, 0, 1); push(6'b101011, 1, 1); push(6'b101011, 2, 1); push(6'b101011, 5, 1);
    push(6'b000100, 0, 1); push(6'b000100, 1, 1); push(6'b000100, 8, 1);
    push(6'b000010, 0, 1); push(6'b000010, 1, 1); push(6'b000010, 9, 1);
    // illegal opcode
    push(6'b111111, 0, 1); push(6'b111111, 1, 1, 1);
`ifdef MULTICYCLE_ADDI_EN
    push(6'b001000, 0, 1); push(6'b001000, 1, 1); push(6'b001000, 10, 1); push(6'b001000, 11, 1);
`else
    push(6'b001000, 0, 1); push(6'b001000, 1, 1, 1);
`endif
    // reset while MEM_WRITE is waiting aborts the store
    push(6'b101011, 0, 1); push(6'b101011, 1, 1); push(6'b101011, 2, 1); push(6'b101011, 5, 0);
    push(6'b101011, 5, 1, 0, 0);
    push(0, 0, 1); push(0, 1, 1); push(0, 6, 1); push(0, 7, 1); push(0, 0, 1);
    drain();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS datapath built from the existing ALU, register file, sign-extend and mux blocks.
- One shared memory serves both instruction fetch and data access.
- Decodes the opcode from the instruction register and steps each instruction through fetch / decode / execute / memory / writeback.
- Stalls on a memory ready handshake, flags unsupported opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word opcode.
- OP_SW, 6'b101011, store word opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- OP_J, 6'b000010, jump opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  instruction register bits [31:26].
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback select: 1 = memory data register.
- reg_dst  out  1  write register select: 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-ext, 11 = sign-ext<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALU out register, 10 = jump address.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_dbg  out  4  current state encoding.
- instr_retired  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset:
  - clk and rst_n only; reset is synchronous and active-low, sampled on rising clk.
  - Reset forces state FETCH (0), instr_retired = 0, illegal_op = 0.
  - Reset outputs are the FETCH values: mem_read = 1, alu_src_b = 01, all other controls 0.
  - Reset asserted mid-instruction aborts it with no register or memory write on that edge.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write = mem_ready (Mealy gating).
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Next state: lw/sw -> MEM_ADDR; R-type -> EXECUTE; beq -> BRANCH; j -> JUMP.
  - Any other opcode -> FETCH with illegal_op = 1 for that cycle; no counter increment.
- MEM_ADDR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Next state: lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read = 1, i_or_d = 1; holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0; then FETCH, retire.
- MEM_WRITE: mem_write = 1, i_or_d = 1; holds until mem_ready, then FETCH, retire.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10; then ALU_WB.
- ALU_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; then FETCH, retire.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01; then FETCH, retire.
- JUMP: pc_write = 1, pc_source = 10; then FETCH, retire.
- Handshake rules:
  - mem_read / mem_write stay asserted and stable until the cycle mem_ready = 1.
  - mem_ready is ignored in all non-memory states.
- Counter:
  - "Retire" = instr_retired increments by 1 on the transition into FETCH.
  - Wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0.
- Latencies with zero wait states: lw 5, sw 4, R-type 4, beq 3, j 3 cycles.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- When defined, opcode 6'b001000 (addi) is legal:
  - DECODE -> ADDI_EX (alu_src_a = 1, alu_src_b = 10, alu_op = 00).
  - ADDI_EX -> ADDI_WB (reg_write = 1, reg_dst = 0, mem_to_reg = 0).
  - ADDI_WB -> FETCH, retire; 4 cycles total.
- When undefined, addi is illegal: illegal_op pulse, states 10/11 unreachable.

Test Plan:
- rst_n low 2 cycles with mem_ready = 1 -> state_dbg = 0, mem_read = 1, alu_src_b = 01, instr_retired = 0, all other controls 0.
- R-type (opcode 0), mem_ready = 1 -> states 0,1,6,7,0; reg_write = 1 and reg_dst = 1 only in state 7; instr_retired = 1 after 4 cycles.
- lw with mem_ready held low 3 cycles in MEM_READ -> state_dbg = 3 held with mem_read = 1 and i_or_d = 1 throughout; MEM_WB follows with mem_to_reg = 1; lw takes 8 cycles.
- sw then beq then j -> pc_write_cond = 1 only in state 8, pc_source = 10 with pc_write = 1 in state 9; instr_retired = 3 after 10 cycles.
- Opcode 6'b111111 -> illegal_op high exactly one cycle in DECODE, return to FETCH, instr_retired unchanged; addi behaves per MULTICYCLE_ADDI_EN setting.
- rst_n low during MEM_WRITE -> next state FETCH, mem_write = 0, counter cleared.
